// File: rtl/regfile_pkg.sv
// Shared widths, types and the write-port priority helper for the multi-port
// integer register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 2**REG_ADDR_W;
    // Upper bound on write ports handled by the priority helper.
    localparam int MAX_WR     = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

    // Index of the highest set bit; later ports overwrite earlier ones, so the
    // result is the winning write port. Returns 0 when nothing matches.
    function automatic int last_match(input logic [MAX_WR-1:0] match);
        last_match = 0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (match[i]) last_match = i;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
// A same-edge issue beats a writeback to the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    output logic [2**ADDR_W-1:0]     busy
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (issue_valid && !(ZERO_REG != 0 && issue_addr == '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (flush) busy_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: data array, write arbitration,
// read/bypass muxes, and the pending-write scoreboard for RAW stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rs_data,
    output logic [NUM_RD-1:0]        o_rs_busy,
    input  logic [NUM_WR*ADDR_W-1:0] i_rd_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_rd_data,
    input  logic [NUM_WR-1:0]        i_rd_wren,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_addr,
    input  logic                     i_flush
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;

    // NOTE: the array is reset because an asynchronous clear of every register is
    // part of the contract; this keeps it in flops rather than a RAM macro.
    // Ports are applied in ascending order so the highest-indexed port wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            regs <= '{default: '0};
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_rd_wren[w] &&
                    !(ZERO_REG != 0 && i_rd_addr[w*ADDR_W +: ADDR_W] == '0)) begin
                    regs[i_rd_addr[w*ADDR_W +: ADDR_W]] <= i_rd_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .wr_addr     (i_rd_addr),
        .wr_en       (i_rd_wren),
        .issue_valid (i_issue_valid),
        .issue_addr  (i_issue_addr),
        .flush       (i_flush),
        .busy        (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [MAX_WR-1:0] hit;
        int                hi;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;

        assign ra = i_rs_addr[k*ADDR_W +: ADDR_W];

        // Write data is never forwarded under reset, so outputs read zero then.
        always_comb begin
            hit = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                hit[w] = i_rd_wren[w] && !i_reset && (i_rd_addr[w*ADDR_W +: ADDR_W] == ra);
            end
            hi    = last_match(hit);
            rdata = regs[ra];
            rbusy = busy[ra];
            if (BYPASS != 0 && hit != '0) begin
                rdata = i_rd_data[hi*DATA_W +: DATA_W];
                rbusy = 1'b0;
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rdata = '0;
                rbusy = 1'b0;
            end
        end

        assign o_rs_data[k*DATA_W +: DATA_W] = rdata;
        assign o_rs_busy[k]                  = rbusy;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with an integrated pending-write scoreboard, for the pipelined/superscalar RV32I core.
- Generalises the single-write, dual-read regfile: configurable width, depth, read-port count and write-port count.
- Optional same-cycle write-to-read bypass.
- Per-register busy bits that let decode stall on RAW hazards.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = read ports return the data being written this cycle; 0 = read returns the stored value
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset  input  1  asynchronous, active-high reset
i_rs_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
o_rs_data  output  NUM_RD*DATA_W  read data, combinational; port k at [k*DATA_W +: DATA_W]
o_rs_busy  output  NUM_RD  1 = the addressed register has a pending write
i_rd_addr  input  NUM_WR*ADDR_W  write addresses, packed per port
i_rd_data  input  NUM_WR*DATA_W  write data, packed per port
i_rd_wren  input  NUM_WR  per-port write enable; a write also clears that register's busy bit
i_issue_valid  input  1  an instruction issues with a destination register this cycle
i_issue_addr  input  ADDR_W  destination register of the issuing instruction
i_flush  input  1  pipeline flush; clears every busy bit

Behaviour:
- Reset: asynchronous on i_reset high, including mid-operation. All registers become 0 and all busy bits become 0 immediately.
  - Consequently o_rs_data = 0 and o_rs_busy = 0 on every port while reset is asserted.
  - Writes, issues and flushes are ignored while reset is high.
- Write (rising edge): for each port w with i_rd_wren[w]=1, reg[addr_w] <= data_w. Write latency is 1 cycle.
- Write collision: if two or more enabled ports target the same address, the highest-indexed port wins.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of any write in flight.
  - o_rs_busy for address 0 is always 0.
- Read: combinational from the array; there is no read latency.
- BYPASS=1: if any enabled write port targets the read address in the same cycle, o_rs_data returns that write data.
  - With multiple matching ports, the highest-indexed port's data is returned, consistent with the collision rule.
  - The zero-register rule overrides the bypass.
- BYPASS=0: a read returns the new value only from the cycle after the write edge.
- Scoreboard, per register:
  - i_issue_valid sets busy[i_issue_addr] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - Same-edge issue and writeback to the same address: busy stays 1, because the new producer wins.
  - i_flush=1 clears all busy bits and overrides a simultaneous issue.
  - Writes still update data during a flush.
  - Issue to an address that is already busy leaves it busy (no counting).
- o_rs_busy[k] = busy[rs_addr_k], registered state only; no bypass of the issue input.
  - With BYPASS=1, a write to the addressed register in the current cycle forces o_rs_busy[k]=0, since the data is being forwarded.
- There is no back-pressure and no handshake. Every write and every issue is accepted.

Decomposition:
- Package regfile_pkg:
  - DEPTH = 2**ADDR_W.
  - Typedef reg_addr_t = logic [ADDR_W-1:0].
  - Typedef reg_data_t = logic [DATA_W-1:0].
  - Helper function for priority selection of the highest-indexed matching write port.
- Sub-module regfile_scoreboard: holds the busy-bit vector and the issue/writeback/flush priority logic.
- Data array, write arbitration and read/bypass muxes live in regfile_mp.

Test Plan:
1. Assert i_reset for 2 cycles after arbitrary prior writes; read regs 0, 5 and 31 → all 0000_0000 and o_rs_busy=0. Assert reset mid-write → the write is lost and the reg reads 0.
2. Port0 writes r5=DEADBEEF and port1 writes r10=12345678 on the same edge; next cycle read r5 and r10 → DEADBEEF and 12345678.
3. Port0 writes r7=11111111 and port1 writes r7=22222222 on the same edge → r7 reads 22222222. Write r0=FFFFFFFF → r0 reads 00000000.
4. With BYPASS=1, write r3=CAFEBABE while reading r3 in the same cycle → o_rs_data=CAFEBABE combinationally and busy=0. With BYPASS=0 → old value that cycle, CAFEBABE the next.
5. Issue r9 → o_rs_busy=1 next cycle. Write r9=55AA55AA together with a new issue of r9 → busy stays 1. A write with no issue → busy=0.
6. Issue r4, r6 and r8 across three cycles, then assert i_flush together with an issue of r12 → all busy=0 including r12. Issue r0 → busy remains 0.
